// File: rtl/cve2_fp_wb_pkg.sv
// Shared types and defaults for the FP register-file writeback arbiter.
package cve2_fp_wb_pkg;

  localparam int unsigned DefaultDataWidth   = 32;
  localparam int unsigned DefaultStarveLimit = 4;

  typedef struct packed {
    logic [4:0]                  rd;
    logic [DefaultDataWidth-1:0] wdata;
  } wb_req_t;

  typedef enum logic [1:0] {
    WB_SRC_NONE,
    WB_SRC_LSU,
    WB_SRC_FPU
  } wb_src_e;

endpackage

// File: rtl/cve2_fp_wb_slot.sv
// One-entry holding register for a writeback source; frees on grant, refills in the same cycle.
module cve2_fp_wb_slot #(
  parameter int unsigned DataWidth = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 valid_i,
  input  logic                 keep_i,
  input  logic [4:0]           rd_i,
  input  logic [DataWidth-1:0] wdata_i,
  output logic                 ready_o,
  input  logic                 grant_i,
  output logic                 slot_valid_o,
  output logic [4:0]           slot_rd_o,
  output logic [DataWidth-1:0] slot_wdata_o
);

  logic                 valid_q, valid_d;
  logic [4:0]           rd_q, rd_d;
  logic [DataWidth-1:0] wdata_q, wdata_d;

  assign ready_o = !rst_i && (!valid_q || grant_i);

  always_comb begin
    valid_d = valid_q;
    rd_d    = rd_q;
    wdata_d = wdata_q;
    if (grant_i) begin
      valid_d = 1'b0;
    end
    // A dropped request still completes its handshake but never occupies the slot.
    if (valid_i && ready_o) begin
      valid_d = keep_i;
      rd_d    = rd_i;
      wdata_d = wdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      rd_q    <= '0;
      wdata_q <= '0;
    end else begin
      valid_q <= valid_d;
      rd_q    <= rd_d;
      wdata_q <= wdata_d;
    end
  end

  assign slot_valid_o = valid_q;
  assign slot_rd_o    = rd_q;
  assign slot_wdata_o = wdata_q;

endmodule

// File: rtl/cve2_fp_wb_arbiter.sv
// FP register-file write-port arbiter (LSU over FPU, with FPU anti-starvation)
// plus a pending-write scoreboard that flags RAW hazards for decode.
module cve2_fp_wb_arbiter
  import cve2_fp_wb_pkg::*;
#(
  parameter bit          RV32E       = 1'b0,
  parameter int unsigned DataWidth   = DefaultDataWidth,
  parameter int unsigned StarveLimit = DefaultStarveLimit
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 issue_valid_i,
  input  logic [4:0]           issue_rd_i,
  input  logic                 ren_a_i,
  input  logic                 ren_b_i,
  input  logic                 ren_c_i,
  input  logic [4:0]           raddr_a_i,
  input  logic [4:0]           raddr_b_i,
  input  logic [4:0]           raddr_c_i,
  output logic                 hazard_o,
  input  logic                 fpu_valid_i,
  output logic                 fpu_ready_o,
  input  logic [4:0]           fpu_rd_i,
  input  logic [DataWidth-1:0] fpu_wdata_i,
  input  logic                 lsu_valid_i,
  output logic                 lsu_ready_o,
  input  logic [4:0]           lsu_rd_i,
  input  logic [DataWidth-1:0] lsu_wdata_i,
  output logic                 rf_we_o,
  output logic [4:0]           rf_waddr_o,
  output logic [DataWidth-1:0] rf_wdata_o,
  output logic                 busy_o
);

  localparam int unsigned AddrWidth = RV32E ? 4 : 5;
  localparam int unsigned NumWords  = 1 << AddrWidth;
  localparam int unsigned CntWidth  = $clog2(StarveLimit + 2);

  logic                 fpu_slot_valid, lsu_slot_valid;
  logic [4:0]           fpu_slot_rd, lsu_slot_rd;
  logic [DataWidth-1:0] fpu_slot_wdata, lsu_slot_wdata;
  logic                 fpu_grant, lsu_grant;
  logic                 fpu_starved;
  wb_src_e              src;

  logic [CntWidth-1:0]  wait_cnt_q, wait_cnt_d;
  logic [NumWords-1:0]  pending_q, pending_d;

  function automatic logic in_range(logic [4:0] addr);
    return !(RV32E && addr[4]);
  endfunction

  cve2_fp_wb_slot #(
    .DataWidth(DataWidth)
  ) u_lsu_slot (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .valid_i     (lsu_valid_i),
    .keep_i      (in_range(lsu_rd_i)),
    .rd_i        (lsu_rd_i),
    .wdata_i     (lsu_wdata_i),
    .ready_o     (lsu_ready_o),
    .grant_i     (lsu_grant),
    .slot_valid_o(lsu_slot_valid),
    .slot_rd_o   (lsu_slot_rd),
    .slot_wdata_o(lsu_slot_wdata)
  );

  cve2_fp_wb_slot #(
    .DataWidth(DataWidth)
  ) u_fpu_slot (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .valid_i     (fpu_valid_i),
    .keep_i      (in_range(fpu_rd_i)),
    .rd_i        (fpu_rd_i),
    .wdata_i     (fpu_wdata_i),
    .ready_o     (fpu_ready_o),
    .grant_i     (fpu_grant),
    .slot_valid_o(fpu_slot_valid),
    .slot_rd_o   (fpu_slot_rd),
    .slot_wdata_o(fpu_slot_wdata)
  );

  assign fpu_starved = (wait_cnt_q == CntWidth'(StarveLimit));

  // No grant while in reset, so held results are discarded without a write.
  always_comb begin
    src = WB_SRC_NONE;
    if (!rst_i) begin
      if (lsu_slot_valid && !(fpu_slot_valid && fpu_starved)) begin
        src = WB_SRC_LSU;
      end else if (fpu_slot_valid) begin
        src = WB_SRC_FPU;
      end
    end
  end

  assign lsu_grant = (src == WB_SRC_LSU);
  assign fpu_grant = (src == WB_SRC_FPU);

  always_comb begin
    rf_we_o    = 1'b0;
    rf_waddr_o = '0;
    rf_wdata_o = '0;
    unique case (src)
      WB_SRC_LSU: begin
        rf_we_o    = 1'b1;
        rf_waddr_o = lsu_slot_rd;
        rf_wdata_o = lsu_slot_wdata;
      end
      WB_SRC_FPU: begin
        rf_we_o    = 1'b1;
        rf_waddr_o = fpu_slot_rd;
        rf_wdata_o = fpu_slot_wdata;
      end
      default: ;
    endcase
  end

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!fpu_slot_valid || fpu_grant) begin
      wait_cnt_d = '0;
    end else if (!fpu_starved) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end
  end

  // Clear first, then set, so an issue wins over a same-cycle write to the same register.
  always_comb begin
    pending_d = pending_q;
    if (rf_we_o) begin
      pending_d[rf_waddr_o[AddrWidth-1:0]] = 1'b0;
    end
    if (issue_valid_i && in_range(issue_rd_i)) begin
      pending_d[issue_rd_i[AddrWidth-1:0]] = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wait_cnt_q <= '0;
      pending_q  <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      pending_q  <= pending_d;
    end
  end

  assign hazard_o = (ren_a_i && in_range(raddr_a_i) && pending_q[raddr_a_i[AddrWidth-1:0]]) ||
                    (ren_b_i && in_range(raddr_b_i) && pending_q[raddr_b_i[AddrWidth-1:0]]) ||
                    (ren_c_i && in_range(raddr_c_i) && pending_q[raddr_c_i[AddrWidth-1:0]]);

  assign busy_o = lsu_slot_valid || fpu_slot_valid || (|pending_q);

endmodule
